// File: rtl/avmm_rd_pkg.sv
// Shared types and the address-derived beat pattern for the Avalon-MM read responder.
package avmm_rd_pkg;

  localparam int unsigned BEAT_BYTES  = 8;
  localparam int unsigned ADDR_LSB    = 3;
  localparam int unsigned WORD_ADDR_W = 61;
  localparam int unsigned BCNT_W      = 8;
  localparam int unsigned SEED_W      = 32;

  // burstcount holds the effective beat count (a request of 0 is stored as 1)
  typedef struct packed {
    logic [WORD_ADDR_W-1:0] word_addr;
    logic [BCNT_W-1:0]      burstcount;
    logic [BEAT_BYTES-1:0]  byteenable;
    logic [SEED_W-1:0]      seed;
  } rd_cmd_t;

  function automatic logic [63:0] beat_data(input logic [31:0]           addr,
                                            input logic [SEED_W-1:0]     seed,
                                            input logic [BEAT_BYTES-1:0] be);
    logic [63:0] d;
    d = {addr ^ seed, addr};
    for (int i = 0; i < int'(BEAT_BYTES); i++) begin
      if (!be[i]) d[8*i +: 8] = 8'h00;
    end
    return d;
  endfunction

endpackage

// File: rtl/avmm_rd_cmd_fifo.sv
// Synchronous FIFO of read commands; head is visible whenever empty is low.
module avmm_rd_cmd_fifo
  import avmm_rd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  rd_cmd_t push_cmd,
  input  logic    pop,
  output rd_cmd_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  rd_cmd_t           mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] count;
  logic              push_ok;
  logic              pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == FILL_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + FILL_W'(1);
        2'b01:   count <= count - FILL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avmm_rd_responder.sv
// Avalon-MM pipelined burst read slave returning an address/seed-derived pattern
// with fixed latency, bounded outstanding commands and periodic stall injection.
module avmm_rd_responder
  import avmm_rd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned BURST_WIDTH     = 4,
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   slave_read,
  input  logic [ADDR_WIDTH-1:0]  slave_address,
  input  logic [BURST_WIDTH-1:0] slave_burstcount,
  input  logic [7:0]             slave_byteenable,
  output logic                   slave_waitrequest,
  output logic [DATA_WIDTH-1:0]  slave_readdata,
  output logic                   slave_readdatavalid,
  input  logic [31:0]            cfg_seed,
  input  logic [7:0]             cfg_stall_period,
  output logic [3:0]             outstanding
);

  localparam int unsigned PIPE_STAGES = READ_LATENCY - 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                state, state_nxt;
  rd_cmd_t               cur, cur_nxt;
  logic                  rd_vld, rd_vld_nxt;
  logic                  rd_last, rd_last_nxt;
  logic [DATA_WIDTH-1:0] rd_data, rd_data_nxt;
  logic [3:0]            out_cnt;
  logic [7:0]            stall_cnt;
  logic                  stall_hit;
  logic                  accept;
  logic                  retire;
  rd_cmd_t               acc_cmd;
  logic                  pipe_vld;
  rd_cmd_t               pipe_cmd;
  logic                  q_push, q_pop, q_full, q_empty;
  rd_cmd_t               q_head;
  logic                  src_vld;
  rd_cmd_t               src;
  logic                  load;
  logic                  bypass;

  // Byte address of a beat, wrapped to ADDR_WIDTH and presented as 32 bits.
  function automatic logic [31:0] byte_addr32(input logic [WORD_ADDR_W-1:0] w);
    logic [ADDR_WIDTH-1:0] a;
    a = ADDR_WIDTH'(64'(w) << ADDR_LSB);
    return 32'(a);
  endfunction

  assign stall_hit         = (cfg_stall_period != 8'd0) &&
                             (stall_cnt == cfg_stall_period - 8'd1);
  assign slave_waitrequest = reset || stall_hit || (out_cnt == 4'(MAX_OUTSTANDING));
  assign accept            = slave_read && !slave_waitrequest;
  assign retire            = rd_vld && rd_last;
  assign outstanding       = out_cnt;
  assign slave_readdata    = rd_data;
  assign slave_readdatavalid = rd_vld;

  always_comb begin
    acc_cmd            = '0;
    acc_cmd.word_addr  = WORD_ADDR_W'(slave_address >> ADDR_LSB);
    acc_cmd.burstcount = (slave_burstcount == '0) ? BCNT_W'(1) : BCNT_W'(slave_burstcount);
    acc_cmd.byteenable = slave_byteenable;
    acc_cmd.seed       = cfg_seed;
  end

  // Free-running stall counter; a shrinking period wraps it back to zero at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (cfg_stall_period == 8'd0 || stall_cnt >= cfg_stall_period - 8'd1) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  // Latency pipeline; the registered beat output supplies the final stage.
  generate
    if (PIPE_STAGES == 0) begin : g_no_pipe
      assign pipe_vld = accept;
      assign pipe_cmd = acc_cmd;
    end else begin : g_pipe
      logic    stg_vld [PIPE_STAGES];
      rd_cmd_t stg_cmd [PIPE_STAGES];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < int'(PIPE_STAGES); i++) begin
            stg_vld[i] <= 1'b0;
            stg_cmd[i] <= '0;
          end
        end else begin
          stg_vld[0] <= accept;
          stg_cmd[0] <= acc_cmd;
          for (int i = 1; i < int'(PIPE_STAGES); i++) begin
            stg_vld[i] <= stg_vld[i-1];
            stg_cmd[i] <= stg_cmd[i-1];
          end
        end
      end

      assign pipe_vld = stg_vld[PIPE_STAGES-1];
      assign pipe_cmd = stg_cmd[PIPE_STAGES-1];
    end
  endgenerate

  // Queued commands are older than the one leaving the pipeline, so they go first.
  always_comb begin
    src_vld = !q_empty || pipe_vld;
    src     = q_empty ? pipe_cmd : q_head;
    load    = (state == S_IDLE) && src_vld;
    q_pop   = load && !q_empty;
    bypass  = load && q_empty;
    q_push  = pipe_vld && !bypass && !q_full;
  end

  avmm_rd_cmd_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_ready_q (
    .clk      (clk),
    .reset    (reset),
    .push     (q_push),
    .push_cmd (pipe_cmd),
    .pop      (q_pop),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Beat FSM: cur holds the next beat's word address and the beats still to send.
  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    rd_vld_nxt  = 1'b0;
    rd_last_nxt = 1'b0;
    rd_data_nxt = '0;
    case (state)
      S_IDLE: begin
        if (src_vld) begin
          rd_vld_nxt         = 1'b1;
          rd_last_nxt        = (src.burstcount == BCNT_W'(1));
          rd_data_nxt        = DATA_WIDTH'(beat_data(byte_addr32(src.word_addr),
                                                     src.seed, src.byteenable));
          cur_nxt            = src;
          cur_nxt.word_addr  = src.word_addr + WORD_ADDR_W'(1);
          cur_nxt.burstcount = src.burstcount - BCNT_W'(1);
          if (src.burstcount != BCNT_W'(1)) state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        rd_vld_nxt         = 1'b1;
        rd_last_nxt        = (cur.burstcount == BCNT_W'(1));
        rd_data_nxt        = DATA_WIDTH'(beat_data(byte_addr32(cur.word_addr),
                                                   cur.seed, cur.byteenable));
        cur_nxt.word_addr  = cur.word_addr + WORD_ADDR_W'(1);
        cur_nxt.burstcount = cur.burstcount - BCNT_W'(1);
        if (cur.burstcount == BCNT_W'(1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cur     <= '0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      rd_data <= '0;
      out_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cur     <= cur_nxt;
      rd_vld  <= rd_vld_nxt;
      rd_last <= rd_last_nxt;
      rd_data <= rd_data_nxt;
      case ({accept, retire})
        2'b10:   out_cnt <= out_cnt + 4'd1;
        2'b01:   out_cnt <= out_cnt - 4'd1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_rd_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a
// beat-schedule reference model of the read responder.
module tb_avmm_rd_responder;

  localparam int L    = 2;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        slave_read = 1'b0;
  logic [31:0] slave_address = '0;
  logic [3:0]  slave_burstcount = '0;
  logic [7:0]  slave_byteenable = 8'hFF;
  logic        slave_waitrequest;
  logic [63:0] slave_readdata;
  logic        slave_readdatavalid;
  logic [31:0] cfg_seed = '0;
  logic [7:0]  cfg_stall_period = '0;
  logic [3:0]  outstanding;

  avmm_rd_responder #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (64),
    .BURST_WIDTH     (4),
    .READ_LATENCY    (L),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .slave_read          (slave_read),
    .slave_address       (slave_address),
    .slave_burstcount    (slave_burstcount),
    .slave_byteenable    (slave_byteenable),
    .slave_waitrequest   (slave_waitrequest),
    .slave_readdata      (slave_readdata),
    .slave_readdatavalid (slave_readdatavalid),
    .cfg_seed            (cfg_seed),
    .cfg_stall_period    (cfg_stall_period),
    .outstanding         (outstanding)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: a schedule of future beats, each tagged with its cycle.
  typedef struct {
    int          cyc;
    logic [63:0] data;
    bit          last;
  } beat_t;

  beat_t       sched[$];
  int          m_cyc, m_out, m_last, m_beats;
  bit          m_acc, m_ret, m_vld;
  logic [31:0] c_addr, c_seed;
  logic [7:0]  c_be;
  int          c_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, m_cyc, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_beat(input logic [31:0] base, input int k,
                                           input logic [31:0] seed, input logic [7:0] be);
    logic [31:0] a;
    logic [63:0] mask;
    a = (base & ~32'h7) + 32'(k * 8);
    for (int i = 0; i < 8; i++) mask[8*i +: 8] = {8{be[i]}};
    return {a ^ seed, a} & mask;
  endfunction

  // Compare DUT outputs with the model for the current cycle (called mid-cycle).
  task automatic sample();
    logic        exp_wr;
    logic [63:0] exp_data;
    int          p;
    p        = int'(cfg_stall_period);
    exp_wr   = (m_out == MAXO) || (p != 0 && (m_cyc % p) == p - 1);
    m_vld    = (sched.size() > 0) && (sched[0].cyc == m_cyc);
    exp_data = m_vld ? sched[0].data : 64'd0;
    chk("waitrequest", 64'(slave_waitrequest), 64'(exp_wr));
    chk("readdatavalid", 64'(slave_readdatavalid), 64'(m_vld));
    chk("readdata", slave_readdata, exp_data);
    chk("outstanding", 64'(outstanding), 64'(m_out));
    m_acc  = slave_read && !exp_wr;
    m_ret  = m_vld && sched[0].last;
    c_addr = slave_address;
    c_seed = cfg_seed;
    c_be   = slave_byteenable;
    c_n    = (slave_burstcount == 4'd0) ? 1 : int'(slave_burstcount);
  endtask

  task automatic advance();
    beat_t b;
    int    start;
    if (m_vld) begin
      void'(sched.pop_front());
      m_beats++;
    end
    if (m_acc) begin
      start = m_cyc + L;
      if (m_last + 1 > start) start = m_last + 1;
      for (int k = 0; k < c_n; k++) begin
        b.cyc  = start + k;
        b.data = ref_beat(c_addr, k, c_seed, c_be);
        b.last = (k == c_n - 1);
        sched.push_back(b);
      end
      m_last = start + c_n - 1;
    end
    m_out = m_out + int'(m_acc) - int'(m_ret);
    m_cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset      = 1'b1;
    slave_read = 1'b0;
    sched.delete();
    m_out  = 0;
    m_last = -1;
    m_acc  = 0;
    m_ret  = 0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_waitrequest", 64'(slave_waitrequest), 64'd1);
    chk("rst_readdatavalid", 64'(slave_readdatavalid), 64'd0);
    chk("rst_readdata", slave_readdata, 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    reset = 1'b0;
    m_cyc = 0;
  endtask

  task automatic drain();
    slave_read = 1'b0;
    for (int i = 0; i < 200 && (sched.size() > 0 || m_out > 0); i++) tick();
    repeat (3) tick();
  endtask

  task automatic set_cmd(input logic [31:0] a, input logic [3:0] bc,
                         input logic [7:0] be, input logic [31:0] seed);
    slave_read       = 1'b1;
    slave_address    = a;
    slave_burstcount = bc;
    slave_byteenable = be;
    cfg_seed         = seed;
  endtask

  task automatic single_0x100();
    set_cmd(32'h100, 4'd1, 8'hFF, 32'h0);
    tick();
    slave_read = 1'b0;
    tick();
    chk("s1_valid", 64'(slave_readdatavalid), 64'd1);
    chk("s1_data", slave_readdata, 64'h00000100_00000100);
    chk("s1_outstanding", 64'(outstanding), 64'd1);
    drain();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int base;
    m_beats = 0;
    m_cyc   = 0;

    // Single read right after reset
    do_reset(3);
    single_0x100();

    // Four-beat burst with a seed
    set_cmd(32'h1000, 4'd4, 8'hFF, 32'hFFFF0000);
    tick();
    drain();

    // Six back-to-back singles with read held high
    n_acc = 0;
    for (int i = 0; i < 40 && n_acc < 6; i++) begin
      set_cmd(32'h2000 + 32'(n_acc * 8), 4'd1, 8'hFF, 32'h0);
      tick();
      if (m_acc) n_acc++;
    end
    drain();

    // Stall injection every third cycle with read held high
    cfg_stall_period = 8'd3;
    do_reset(2);
    for (int i = 0; i < 24; i++) begin
      set_cmd($urandom, 4'd1, 8'hFF, $urandom);
      tick();
    end
    drain();

    // Partial byteenable, zero burstcount and address wrap
    cfg_stall_period = 8'd0;
    do_reset(2);
    set_cmd(32'h20, 4'd0, 8'h0F, 32'h0);
    tick();
    set_cmd(32'hFFFF_FFF0, 4'd4, 8'hA5, 32'h1234_5678);
    tick();
    drain();

    // Random traffic under several stall periods
    for (int ph = 0; ph < 3; ph++) begin
      cfg_stall_period = (ph == 0) ? 8'd0 : 8'($urandom_range(2, 7));
      do_reset(2);
      for (int i = 0; i < 150; i++) begin
        set_cmd($urandom, 4'($urandom_range(0, 15)), 8'($urandom), $urandom);
        slave_read = ($urandom_range(0, 3) != 0);
        tick();
      end
      drain();
    end

    // Reset between the second and third beat of a burst
    cfg_stall_period = 8'd0;
    do_reset(2);
    set_cmd(32'h3000, 4'd4, 8'hFF, 32'h0);
    tick();
    slave_read = 1'b0;
    base = m_beats;
    for (int i = 0; i < 20 && m_beats - base < 2; i++) tick();
    reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(slave_readdatavalid), 64'd0);
    chk("midrst_data", slave_readdata, 64'd0);
    chk("midrst_outstanding", 64'(outstanding), 64'd0);
    chk("midrst_waitrequest", 64'(slave_waitrequest), 64'd1);
    do_reset(2);
    repeat (4) tick();
    single_0x100();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
